// File: rtl/hack_cpu_core.sv
// Multi-cycle Hack CPU core: FETCH/DECODE/EXEC sequencing, A/D/PC/IR
// registers and write-back around the Hack ALU.

module hack_alu (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        zx,
    input  logic        nx,
    input  logic        zy,
    input  logic        ny,
    input  logic        f,
    input  logic        no,
    output logic [15:0] out,
    output logic        zr,
    output logic        ng
);

    logic [15:0] x_z, x_n, y_z, y_n, f_out;

    always_comb begin
        x_z   = zx ? 16'h0000 : x;
        x_n   = nx ? ~x_z : x_z;
        y_z   = zy ? 16'h0000 : y;
        y_n   = ny ? ~y_z : y_z;
        f_out = f ? (x_n + y_n) : (x_n & y_n);
        out   = no ? ~f_out : f_out;
        zr    = (out == 16'h0000);
        ng    = out[15];
    end

endmodule

module hack_cpu_core #(
    parameter int PC_WIDTH   = 15,
    parameter int ADDR_WIDTH = 15
) (
    input  logic                  i_Clk,
    input  logic                  i_Reset,
    input  logic [15:0]           i_Instr,
    output logic [PC_WIDTH-1:0]   o_PC,
    input  logic [15:0]           i_InM,
    output logic [ADDR_WIDTH-1:0] o_AddrM,
    output logic [15:0]           o_OutM,
    output logic                  o_WriteM,
    output logic                  o_InstrDone
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2
    } state_t;

    state_t state, state_next;

    logic [PC_WIDTH-1:0] pc, pc_inc;
    logic [15:0]         a, d, ir;
    logic [15:0]         alu_y, alu_out;
    logic                zr, ng;
    logic                is_c, exec, take;
    logic                unused_ir;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            FETCH:   state_next = DECODE;
            DECODE:  state_next = EXEC;
            EXEC:    state_next = FETCH;
            default: state_next = FETCH;
        endcase
    end

    assign is_c      = ir[15];
    assign exec      = (state == EXEC);
    assign alu_y     = ir[12] ? i_InM : a;
    assign pc_inc    = pc + PC_WIDTH'(1);
    assign unused_ir = ^ir[14:13];

    hack_alu u_alu (
        .x   (d),
        .y   (alu_y),
        .zx  (ir[11]),
        .nx  (ir[10]),
        .zy  (ir[9]),
        .ny  (ir[8]),
        .f   (ir[7]),
        .no  (ir[6]),
        .out (alu_out),
        .zr  (zr),
        .ng  (ng)
    );

    assign take = (ir[2] & ng) | (ir[1] & zr) | (ir[0] & ~ng & ~zr);

    // A and D change only at the end of EXEC, so the M address and the
    // jump target both see the pre-instruction A.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            pc <= '0;
            a  <= '0;
            d  <= '0;
            ir <= '0;
        end else begin
            if (state == DECODE) begin
                ir <= i_Instr;
            end
            if (exec) begin
                if (!is_c) begin
                    a  <= {1'b0, ir[14:0]};
                    pc <= pc_inc;
                end else begin
                    if (ir[5]) a <= alu_out;
                    if (ir[4]) d <= alu_out;
                    pc <= take ? a[PC_WIDTH-1:0] : pc_inc;
                end
            end
        end
    end

    assign o_PC        = pc;
    assign o_AddrM     = a[ADDR_WIDTH-1:0];
    assign o_OutM      = alu_out;
    assign o_WriteM    = exec & is_c & ir[3] & ~i_Reset;
    assign o_InstrDone = exec & ~i_Reset;

endmodule

// File: tb/tb_hack_cpu_core.sv
// Bench for hack_cpu_core: directed program plus random ROM contents,
// checked per instruction against an architectural Hack model.

module tb_hack_cpu_core;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr, in_m, out_m;
    logic [14:0] pc, addr;
    logic        wm, done;

    always #5 clk = ~clk;

    hack_cpu_core #(.PC_WIDTH(15), .ADDR_WIDTH(15)) dut (
        .i_Clk       (clk),
        .i_Reset     (rst),
        .i_Instr     (instr),
        .o_PC        (pc),
        .i_InM       (in_m),
        .o_AddrM     (addr),
        .o_OutM      (out_m),
        .o_WriteM    (wm),
        .o_InstrDone (done)
    );

    logic [15:0] rom  [0:32767];
    logic [15:0] ram  [0:32767];
    logic [15:0] mram [0:32767];

    always @(posedge clk) begin
        instr <= rom[pc];
        in_m  <= ram[addr];
        if (wm) ram[addr] <= out_m;
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [15:0] ma, md;
    logic [14:0] mpc;
    logic        lw_valid;
    logic [14:0] lw_addr;
    logic [15:0] lw_data;

    function automatic logic [15:0] alu(input logic [15:0] x,
                                        input logic [15:0] y,
                                        input logic [5:0] c);
        logic [15:0] xx, yy, o;
        xx = c[5] ? 16'h0 : x;
        if (c[4]) xx = ~xx;
        yy = c[3] ? 16'h0 : y;
        if (c[2]) yy = ~yy;
        o = c[1] ? xx + yy : xx & yy;
        if (c[0]) o = ~o;
        return o;
    endfunction

    task automatic model_reset();
        ma  = 16'h0;
        md  = 16'h0;
        mpc = 15'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("rst_pc", pc, 0);
        check("rst_addr", addr, 0);
        check("rst_wm", wm, 0);
        check("rst_done", done, 0);
    endtask

    // From a FETCH-cycle negedge, advance to the EXEC negedge.
    task automatic wait_exec(output bit ok);
        int n;
        n  = 0;
        ok = 1'b1;
        while (!done) begin
            check("idle_wm", wm, 0);
            @(negedge clk);
            n++;
            if (n > 8) begin
                check("exec_timeout", 1, 0);
                ok = 1'b0;
                return;
            end
        end
        check("exec_latency", n, 2);
    endtask

    task automatic exec_check();
        logic [15:0] ir, y, o, na, nd;
        logic [14:0] npc;
        logic        expw, neg, z, tk;
        ir = rom[mpc];
        check("exec_pc", pc, mpc);
        check("exec_addr", addr, ma[14:0]);
        na   = ma;
        nd   = md;
        expw = 1'b0;
        if (!ir[15]) begin
            na  = {1'b0, ir[14:0]};
            npc = mpc + 15'd1;
        end else begin
            y    = ir[12] ? mram[ma[14:0]] : ma;
            o    = alu(md, y, ir[11:6]);
            neg  = o[15];
            z    = (o == 16'h0);
            tk   = (ir[2] && neg) || (ir[1] && z) || (ir[0] && !neg && !z);
            expw = ir[3];
            if (expw) mram[ma[14:0]] = o;
            if (ir[5]) na = o;
            if (ir[4]) nd = o;
            npc = tk ? ma[14:0] : mpc + 15'd1;
            if (expw) check("out_m", out_m, o);
        end
        check("write_en", wm, expw);
        lw_valid = wm;
        lw_addr  = addr;
        lw_data  = out_m;
        ma  = na;
        md  = nd;
        mpc = npc;
        @(negedge clk);
        check("next_pc", pc, mpc);
        check("next_addr", addr, ma[14:0]);
        check("write_pulse", wm, 0);
    endtask

    task automatic step(output bit ok);
        wait_exec(ok);
        if (ok) exec_check();
    endtask

    bit ok;

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 32768; i++) begin
            rom[i]  = 16'h0;
            ram[i]  = 16'h0;
            mram[i] = 16'h0;
        end
        rom[0]  = 16'h0005;
        rom[1]  = 16'hEC10;
        rom[2]  = 16'h0064;
        rom[3]  = 16'hE7C8;
        rom[4]  = 16'h0007;
        rom[5]  = 16'hEC10;
        rom[6]  = 16'h0014;
        rom[7]  = 16'hE301;
        rom[20] = 16'hEA90;
        rom[21] = 16'h001E;
        rom[22] = 16'hE301;
        rom[23] = 16'h0028;
        rom[24] = 16'hEA87;
        rom[40] = 16'h0003;
        rom[41] = 16'hFDE8;
        rom[42] = 16'h7FFF;
        rom[43] = 16'hEA87;
        rom[32767] = 16'h0001;
        ram[3]  = 16'd9;
        mram[3] = 16'd9;

        do_reset();
        for (int i = 0; i < 18; i++) begin
            step(ok);
            if (!ok) break;
            case (i)
                0: begin
                    check("a_inst_a", addr, 5);
                    check("a_inst_pc", pc, 1);
                    check("a_inst_wm", lw_valid, 0);
                end
                1: check("d_eq_a_pc", pc, 2);
                3: begin
                    check("mdp1_we", lw_valid, 1);
                    check("mdp1_addr", lw_addr, 100);
                    check("mdp1_data", lw_data, 6);
                end
                7:  check("jgt_taken", pc, 20);
                10: check("jgt_not", pc, 23);
                12: check("jmp", pc, 40);
                14: begin
                    check("am_we", lw_valid, 1);
                    check("am_addr", lw_addr, 3);
                    check("am_data", lw_data, 10);
                    check("am_new_a", addr, 10);
                end
                16: check("jmp_max", pc, 15'h7FFF);
                17: check("pc_wrap", pc, 0);
                default: ;
            endcase
        end

        ram[100]  = 16'h0;
        mram[100] = 16'h0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(ok);
            if (!ok) break;
        end
        wait_exec(ok);
        rst = 1'b1;
        #1;
        check("rst_exec_wm", wm, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("rst_exec_pc", pc, 0);
        check("rst_exec_a", addr, 0);
        check("rst_exec_done", done, 0);
        check("rst_exec_ram", ram[100], 0);

        rom[0] = 16'h00C8;
        rom[1] = 16'hE308;
        for (int i = 0; i < 2; i++) begin
            step(ok);
            if (!ok) break;
        end
        check("d_reset_we", lw_valid, 1);
        check("d_reset_val", lw_data, 0);
        check("d_reset_addr", lw_addr, 200);

        for (int i = 0; i < 32768; i++) begin
            rom[i]  = 16'($urandom);
            ram[i]  = 16'($urandom);
            mram[i] = ram[i];
        end
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(ok);
            if (!ok) break;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hack_cpu_core.md
Name: hack_cpu_core

Overview:
Multi-cycle Hack CPU core that sits directly upstream of the existing ALU. It fetches instructions from synchronous instruction ROM, decodes A- and C-instructions, holds the A, D and PC registers, and drives the ALU operands and control bits. It consumes the ALU result and flags for write-back and jumps, and drives the data-memory interface. The core instantiates ALU internally; the ROM and RAM are external synchronous BRAMs with 1-cycle read latency.

Parameters:
PC_WIDTH, 15, width of program counter and of o_PC.
ADDR_WIDTH, 15, width of data-memory address o_AddrM, taken from A[ADDR_WIDTH-1:0].

Ports:
i_Clk  in  1  system clock; all state updates on rising edge.
i_Reset  in  1  synchronous, active-high reset.
i_Instr  in  16  ROM read data; valid the cycle after o_PC is presented.
o_PC  out  PC_WIDTH  instruction ROM address; equals the PC register.
i_InM  in  16  RAM read data; valid the cycle after o_AddrM is presented.
o_AddrM  out  ADDR_WIDTH  data-memory address; equals A[ADDR_WIDTH-1:0].
o_OutM  out  16  data to write to RAM; equals the ALU output.
o_WriteM  out  1  RAM write enable; 1-cycle pulse.
o_InstrDone  out  1  1-cycle pulse in the EXEC cycle of every instruction, for the bench.

Behaviour:
- Clock and reset: one clock (i_Clk); reset (i_Reset) is synchronous and active-high.
- FSM states and sequence: FETCH -> DECODE -> EXEC -> FETCH. Every instruction takes exactly 3 cycles, with no stalls.
- FETCH:
  - o_PC = PC; ROM registers the address.
- DECODE:
  - IR <= i_Instr.
  - o_AddrM continues to show the current A, so RAM begins reading M[A].
- EXEC:
  - i_InM is valid.
  - The ALU is fed X = D and Y = (IR[12] ? i_InM : A).
  - ALU controls: zx..no = IR[11:6].
- A-instruction (IR[15]=0), in EXEC:
  - A <= {1'b0, IR[14:0]}.
  - PC <= PC+1.
  - No memory write.
- C-instruction (IR[15]=1), in EXEC:
  - dest bits IR[5:3] = {A, D, M}.
  - If d3: o_WriteM=1, with o_AddrM = old A and o_OutM = ALU out.
  - If d1: A <= ALU out. If d2: D <= ALU out.
  - A and D updates take effect at the end of EXEC, so the M address always uses the pre-instruction A.
  - IR[14:13] are ignored.
- Jump:
  - take = (j1 & ng) | (j2 & zr) | (j3 & ~ng & ~zr), where j = IR[2:0] = {j1, j2, j3}.
  - If take: PC <= old A[PC_WIDTH-1:0]; else PC <= PC+1.
  - A dest update and jump in the same instruction: the jump target is the old A.
- o_WriteM and o_InstrDone are high only in EXEC and are combinational from state/IR; they are 0 in all other states.
- Arithmetic: all ALU math is 16-bit modulo (inside the ALU). PC+1 wraps from 2^PC_WIDTH-1 to 0.
- Reset values: state=FETCH, PC=0, A=0, D=0, IR=0. Consequently o_PC=0, o_AddrM=0, o_WriteM=0, o_InstrDone=0 the cycle after reset.
- Reset asserted in any state, including EXEC: that cycle's write-back is suppressed. Reset has priority over every register update, and o_WriteM is forced 0 during reset.
- Fetch after reset: the first fetch occurs the first cycle i_Reset is low.

Test Plan:
1. Reset, ROM[0]=0x0005 (@5) -> after 3 cycles: A=5, PC=1, o_InstrDone pulsed once, o_WriteM never asserted.
2. ROM: @5, 0xEC10 (D=A) -> after 6 cycles: D=5, PC=2.
3. ROM: @5, 0xEC10, @100, 0xE7C8 (M=D+1) -> in the 4th EXEC cycle: o_WriteM=1 for exactly 1 cycle, o_AddrM=100, o_OutM=6.
4. Jumps:
   - D=7, A=20, 0xE301 (D;JGT) -> PC=20.
   - Repeat with D=0 -> PC=old+1.
   - Then 0xEA87 (0;JMP) with A=3 -> PC=3.
5. A=3, RAM[3]=9, 0xFDE8 (AM=M+1) -> o_AddrM=3, o_OutM=10, o_WriteM pulse; afterwards A=10.
6. Boundary and reset cases:
   - PC=0x7FFF executing @1 -> PC wraps to 0.
   - Separately, assert i_Reset during EXEC of M=D+1 -> o_WriteM stays 0, next cycle PC=0, A=0, D=0, state FETCH.
